capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Sequences bursts of decimated IQ samples from the 20 MSPS downsampler output into the CSI extraction path.
- Arms on software command, waits for a trigger, then discards a configurable number of settling samples.
- Forwards exactly N samples as one AXI-Stream frame with tlast on the final sample.
- Outside a capture it sinks and discards input, so the downsampler never stalls.

Parameters:
- CNT_WIDTH, 16, width of sample-count and skip-count fields.
- DATA_WIDTH, 32, stream width ({I[15:0], Q[15:0]}, passed through unmodified).

Ports:
- s00_axis_aclk  in  1  single clock for all logic.
- s00_axis_areset  in  1  reset: synchronous, active-high.
- ctrl_start  in  1  single-cycle pulse; arms a capture.
- ctrl_abort  in  1  single-cycle pulse; cancels any capture.
- ctrl_trigger  in  1  trigger pulse, used while ARMED.
- ctrl_auto_trigger  in  1  when 1, ARMED triggers immediately.
- ctrl_num_samples  in  CNT_WIDTH  frame length N; latched on start.
- ctrl_skip  in  CNT_WIDTH  settling samples K to discard; latched on start.
- s00_axis_tvalid  in  1  upstream valid.
- s00_axis_tdata  in  DATA_WIDTH  upstream sample.
- s00_axis_tready  out  1  upstream ready.
- m00_axis_tvalid  out  1  downstream valid.
- m00_axis_tdata  out  DATA_WIDTH  downstream sample.
- m00_axis_tlast  out  1  marks the final sample of a frame.
- m00_axis_tready  in  1  downstream ready.
- status_busy  out  1  high from an accepted start until done or abort.
- status_state  out  2  0=IDLE, 1=ARMED, 2=SKIP, 3=CAPTURE.
- status_done  out  1  one-cycle pulse on the tlast output handshake.
- status_aborted  out  1  one-cycle pulse when an abort takes effect.
- status_dropped  out  CNT_WIDTH  count of beats discarded in ARMED; saturating; cleared on accepted start.

Behaviour:
- Reset: state IDLE. All outputs 0, including tdata, tlast, status_dropped and internal counters. Exception: s00_axis_tready reads 1 in IDLE, and this holds during reset.
- Beat: the cycle where s00_axis_tvalid && s00_axis_tready.
- s00_axis_tready:
  - IDLE, ARMED, SKIP: 1; beats are discarded.
  - CAPTURE: m00_axis_tready || ~m00_axis_tvalid.
- Output is a single register stage, giving 1-cycle latency and full-rate throughput. m00_axis_tvalid and tdata never change while tvalid && ~tready.
- IDLE:
  - ctrl_start && ~status_busy && ctrl_num_samples!=0 → ARMED next cycle.
  - On that start: latch N and K, clear capture counter and status_dropped, assert status_busy.
  - Start with N==0, or start while busy: ignored, no status change.
- ARMED:
  - Each discarded beat increments status_dropped, saturating at all-ones.
  - (ctrl_trigger || ctrl_auto_trigger) → SKIP if K>0, else CAPTURE, next cycle.
  - A beat in the trigger cycle is discarded.
- SKIP: counts discarded beats; on the K-th beat → CAPTURE next cycle.
- CAPTURE:
  - Each beat loads the output register and increments the capture count.
  - The beat with count==N-1 loads with tlast=1, and the state returns to IDLE next cycle.
  - status_busy stays high until that beat handshakes downstream. status_done pulses in that handshake cycle and status_busy clears the following cycle.
  - Subsequent input in IDLE is discarded and does not disturb the pending output beat.
- Abort, from any state:
  - State goes to IDLE next cycle; counters clear; status_busy clears; status_aborted pulses once.
  - A pending output beat stays valid until accepted; its tlast is unchanged and no done pulse follows.
  - Abort in IDLE with ~busy: no pulse.
- Simultaneous events:
  - Abort beats start, trigger and beat.
  - Start in the same cycle as a done handshake: ignored, because busy is still high.
- Widths: counters are CNT_WIDTH unsigned; the N-1 compare has no wrap because N≥1.

Test Plan:
- Auto-trigger: N=4, K=0, continuous input 1..20, tready=1 → outputs 1..4 (or the next 4 after arm), tlast on 4th, done pulse once, busy low after; upstream tready stays 1 outside CAPTURE.
- Skip: auto, N=3, K=2, inputs 10,11,12,13,14 from trigger → outputs 12,13,14, tlast on 14.
- Backpressure: N=5, downstream tready toggling 1-0 → tdata stable while stalled; exactly 5 beats out; upstream tready low during stalls.
- Manual trigger: ARMED for 7 input beats then ctrl_trigger, N=2 → status_dropped=8 (including the trigger-cycle beat); next 2 samples forwarded.
- Abort mid-capture: N=10, abort after 3 beats out → aborted pulse; no tlast, no done; state IDLE; a new start with N=2 is accepted and completes normally.
- Edge cases:
  - Start with N=0 → no state change.
  - Start while busy → ignored.
  - Start and abort in the same cycle → IDLE, no arm.
  - Reset mid-CAPTURE → all outputs 0 next cycle.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture sequencer: arms on command, waits for a trigger, drops K settling
// samples, then forwards N samples as one AXI-Stream frame with tlast.
//
// state   | meaning
// IDLE    | no capture; input sunk; a final output beat may still be pending
// ARMED   | waiting for trigger; input beats counted in status_dropped
// SKIP    | discarding K settling beats
// CAPTURE | forwarding beats to the output register until the N-th
module capture_sequencer #(
    parameter int CNT_WIDTH  = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_areset,
    input  logic                  ctrl_start,
    input  logic                  ctrl_abort,
    input  logic                  ctrl_trigger,
    input  logic                  ctrl_auto_trigger,
    input  logic [CNT_WIDTH-1:0]  ctrl_num_samples,
    input  logic [CNT_WIDTH-1:0]  ctrl_skip,
    input  logic                  s00_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    output logic                  s00_axis_tready,
    output logic                  m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    output logic                  status_busy,
    output logic [1:0]            status_state,
    output logic                  status_done,
    output logic                  status_aborted,
    output logic [CNT_WIDTH-1:0]  status_dropped
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_SKIP    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  skip_q, skip_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  dropped_q, dropped_d;
    logic                  busy_q, busy_d;
    logic                  aborted_q, aborted_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;

    logic beat;
    logic done;
    logic start_ok;
    logic is_last;

    // Ready is forced high during reset so the downsampler never sees a stall.
    assign s00_axis_tready = s00_axis_areset | (state_q != ST_CAPTURE)
                           | m00_axis_tready | ~m_valid_q;
    assign beat     = s00_axis_tvalid & s00_axis_tready;
    assign done     = m_valid_q & m00_axis_tready & m_last_q & busy_q;
    assign start_ok = ctrl_start & ~busy_q & ~ctrl_abort & (ctrl_num_samples != '0);
    assign is_last  = (cnt_q == num_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        skip_d    = skip_q;
        cnt_d     = cnt_q;
        dropped_d = dropped_q;
        busy_d    = busy_q;
        aborted_d = 1'b0;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        if (m_valid_q && m00_axis_tready) m_valid_d = 1'b0;
        if (done) busy_d = 1'b0;

        // A pending output beat survives abort untouched; only sequencing stops.
        if (ctrl_abort) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            skip_d    = '0;
            busy_d    = 1'b0;
            aborted_d = busy_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_d   = ST_ARMED;
                        num_d     = ctrl_num_samples;
                        skip_d    = ctrl_skip;
                        cnt_d     = '0;
                        dropped_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (beat && (dropped_q != '1)) dropped_d = dropped_q + 1'b1;
                    if (ctrl_trigger || ctrl_auto_trigger)
                        state_d = (skip_q != '0) ? ST_SKIP : ST_CAPTURE;
                end
                ST_SKIP: begin
                    // skip_q is a down-counter; terminal count on the K-th beat.
                    if (beat) begin
                        skip_d = skip_q - 1'b1;
                        if (skip_q == 1) state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (beat) begin
                        m_valid_d = 1'b1;
                        m_data_d  = s00_axis_tdata;
                        m_last_d  = is_last;
                        cnt_d     = cnt_q + 1'b1;
                        if (is_last) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            skip_q    <= '0;
            cnt_q     <= '0;
            dropped_q <= '0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            skip_q    <= skip_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
            busy_q    <= busy_d;
            aborted_q <= aborted_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m00_axis_tvalid = m_valid_q;
    assign m00_axis_tdata  = m_data_q;
    assign m00_axis_tlast  = m_last_q;
    assign status_busy     = busy_q;
    assign status_state    = state_q;
    assign status_done     = done;
    assign status_aborted  = aborted_q;
    assign status_dropped  = dropped_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: random input beats are logged with a cycle
// stamp and each expected frame is picked from that log by position.
module tb_capture_sequencer;
    localparam int CW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          areset;
    logic          ctrl_start, ctrl_abort, ctrl_trigger, ctrl_auto_trigger;
    logic [CW-1:0] ctrl_num_samples, ctrl_skip;
    logic          s_tvalid, s_tready;
    logic [DW-1:0] s_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [DW-1:0] m_tdata;
    logic          status_busy, status_done, status_aborted;
    logic [1:0]    status_state;
    logic [CW-1:0] status_dropped;

    always #5 clk = ~clk;

    capture_sequencer #(.CNT_WIDTH(CW), .DATA_WIDTH(DW)) dut (
        .s00_axis_aclk     (clk),
        .s00_axis_areset   (areset),
        .ctrl_start        (ctrl_start),
        .ctrl_abort        (ctrl_abort),
        .ctrl_trigger      (ctrl_trigger),
        .ctrl_auto_trigger (ctrl_auto_trigger),
        .ctrl_num_samples  (ctrl_num_samples),
        .ctrl_skip         (ctrl_skip),
        .s00_axis_tvalid   (s_tvalid),
        .s00_axis_tdata    (s_tdata),
        .s00_axis_tready   (s_tready),
        .m00_axis_tvalid   (m_tvalid),
        .m00_axis_tdata    (m_tdata),
        .m00_axis_tlast    (m_tlast),
        .m00_axis_tready   (m_tready),
        .status_busy       (status_busy),
        .status_state      (status_state),
        .status_done       (status_done),
        .status_aborted    (status_aborted),
        .status_dropped    (status_dropped)
    );

    typedef struct { int stamp; logic [DW-1:0] data; } beat_t;
    typedef struct { logic [DW-1:0] data; logic last; } out_t;

    beat_t         beats[$];
    out_t          outs[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            abort_cnt = 0;
    int            dseq = 1;
    bit            cont = 1'b1;
    int            bp = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs beats and handshakes, checks stall behaviour.
    always @(negedge clk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (s_tvalid && s_tready) beats.push_back('{cyc, s_tdata});
            if (m_tvalid && m_tready) outs.push_back('{m_tdata, m_tlast});
            if (status_done) done_cnt++;
            if (status_aborted) abort_cnt++;
            if (prev_stall) begin
                chk("hold_valid", 64'(m_tvalid), 64'd1);
                chk("hold_data", 64'(m_tdata), 64'(prev_data));
                chk("hold_last", 64'(m_tlast), 64'(prev_last));
            end
            if (status_state != 2'd3) chk("up_ready_idle", 64'(s_tready), 64'd1);
            else if (m_tvalid && !m_tready) chk("up_ready_stall", 64'(s_tready), 64'd0);
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic drive();
        s_tvalid = cont ? 1'b1 : ($urandom_range(3) != 0);
        s_tdata  = DW'(dseq);
        dseq++;
        case (bp)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beats.delete();
        outs.delete();
        done_cnt  = 0;
        abort_cnt = 0;
    endtask

    // One full capture; expected frame = beats after the trigger cycle, minus K.
    task automatic run_capture(input string tag, input int n, input int k, input bit au,
                               input int arm, input int bpm, input bit c);
        int            start_cyc, trig_cyc, exp_drop;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] obs_d, exp_d;
        logic          obs_l;
        cont = c;
        bp   = bpm;
        clear_logs();
        ctrl_num_samples  = CW'(n);
        ctrl_skip         = CW'(k);
        ctrl_auto_trigger = au;
        ctrl_start        = 1'b1;
        start_cyc         = cyc;
        drive();
        tick();
        ctrl_start = 1'b0;
        chk({tag, "_armed"}, 64'(status_state), 64'd1);
        chk({tag, "_busy"}, 64'(status_busy), 64'd1);
        chk({tag, "_drop_clr"}, 64'(status_dropped), 64'd0);
        if (au) begin
            trig_cyc = start_cyc + 1;
        end else begin
            repeat (arm) begin drive(); tick(); end
            ctrl_trigger = 1'b1;
            trig_cyc     = cyc;
            drive();
            tick();
            ctrl_trigger = 1'b0;
        end
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin drive(); tick(); end
        ctrl_auto_trigger = 1'b0;
        chk({tag, "_busy_after"}, 64'(status_busy), 64'd0);
        chk({tag, "_idle_after"}, 64'(status_state), 64'd0);
        repeat (3) begin drive(); tick(); end
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        exp_drop = 0;
        foreach (beats[i]) begin
            if (beats[i].stamp > start_cyc && beats[i].stamp <= trig_cyc) exp_drop++;
            else if (beats[i].stamp > trig_cyc) exp_q.push_back(beats[i].data);
        end
        chk({tag, "_dropped"}, 64'(status_dropped), 64'(exp_drop));
        chk({tag, "_count"}, 64'(outs.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            obs_d = (i < outs.size()) ? outs[i].data : 'x;
            obs_l = (i < outs.size()) ? outs[i].last : 1'bx;
            exp_d = (k + i < exp_q.size()) ? exp_q[k + i] : 32'hDEAD_BEEF;
            chk({tag, "_data"}, 64'(obs_d), 64'(exp_d));
            chk({tag, "_last"}, 64'(obs_l), 64'(i == n - 1));
        end
    endtask

    initial begin
        int lastc;
        areset = 1'b1;
        ctrl_start = 0; ctrl_abort = 0; ctrl_trigger = 0; ctrl_auto_trigger = 0;
        ctrl_num_samples = '0; ctrl_skip = '0;
        s_tvalid = 0; s_tdata = '0; m_tready = 1'b1;
        tick();
        tick();
        chk("rst_state", 64'(status_state), 64'd0);
        chk("rst_busy", 64'(status_busy), 64'd0);
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_dropped", 64'(status_dropped), 64'd0);
        chk("rst_sready", 64'(s_tready), 64'd1);
        areset = 1'b0;
        tick();

        run_capture("auto", 4, 0, 1'b1, 0, 0, 1'b1);
        run_capture("skip", 3, 2, 1'b1, 0, 0, 1'b1);
        run_capture("bp", 5, 0, 1'b1, 0, 1, 1'b1);
        run_capture("manual", 2, 0, 1'b0, 7, 0, 1'b1);
        chk("manual_drop8", 64'(status_dropped), 64'd8);

        // Abort mid-capture.
        cont = 1'b1; bp = 0;
        clear_logs();
        ctrl_num_samples = 10; ctrl_skip = 0; ctrl_auto_trigger = 1'b1;
        ctrl_start = 1'b1; drive(); tick(); ctrl_start = 1'b0;
        for (int i = 0; i < 50 && outs.size() < 3; i++) begin drive(); tick(); end
        ctrl_auto_trigger = 1'b0;
        ctrl_abort = 1'b1; drive(); tick(); ctrl_abort = 1'b0;
        chk("abort_state", 64'(status_state), 64'd0);
        chk("abort_busy", 64'(status_busy), 64'd0);
        chk("abort_pulse", 64'(status_aborted), 64'd1);
        repeat (4) begin drive(); tick(); end
        chk("abort_once", 64'(abort_cnt), 64'd1);
        chk("abort_nodone", 64'(done_cnt), 64'd0);
        chk("abort_short", 64'(outs.size() < 10), 64'd1);
        chk("abort_drained", 64'(m_tvalid), 64'd0);
        lastc = 0;
        foreach (outs[i]) if (outs[i].last) lastc++;
        chk("abort_nolast", 64'(lastc), 64'd0);
        run_capture("after_abort", 2, 0, 1'b1, 0, 0, 1'b1);

        // Start with N=0 is ignored.
        ctrl_num_samples = 0; ctrl_start = 1'b1; drive(); tick(); ctrl_start = 1'b0;
        chk("n0_state", 64'(status_state), 64'd0);
        chk("n0_busy", 64'(status_busy), 64'd0);

        // Start while busy is ignored; the original N still governs the frame.
        clear_logs();
        ctrl_num_samples = 3; ctrl_start = 1'b1; drive(); tick(); ctrl_start = 1'b0;
        ctrl_num_samples = 7; ctrl_start = 1'b1; drive(); tick(); ctrl_start = 1'b0;
        chk("busy_start_state", 64'(status_state), 64'd1);
        chk("busy_start_drop", 64'(status_dropped), 64'd1);
        ctrl_trigger = 1'b1; drive(); tick(); ctrl_trigger = 1'b0;
        for (int i = 0; i < 100 && done_cnt == 0; i++) begin drive(); tick(); end
        repeat (2) begin drive(); tick(); end
        chk("busy_start_len", 64'(outs.size()), 64'd3);

        // Start and abort together: abort wins, no pulse from idle.
        ctrl_num_samples = 4; ctrl_start = 1'b1; ctrl_abort = 1'b1; drive(); tick();
        ctrl_start = 1'b0; ctrl_abort = 1'b0;
        chk("sa_state", 64'(status_state), 64'd0);
        chk("sa_busy", 64'(status_busy), 64'd0);
        chk("sa_nopulse", 64'(status_aborted), 64'd0);

        for (int r = 0; r < 6; r++)
            run_capture($sformatf("rand%0d", r), $urandom_range(1, 8), $urandom_range(0, 4),
                        1'($urandom_range(1)), $urandom_range(0, 5), $urandom_range(0, 2), 1'b0);

        // Reset mid-capture.
        cont = 1'b1; bp = 0;
        ctrl_num_samples = 10; ctrl_skip = 0; ctrl_auto_trigger = 1'b1;
        ctrl_start = 1'b1; drive(); tick(); ctrl_start = 1'b0;
        repeat (4) begin drive(); tick(); end
        ctrl_auto_trigger = 1'b0;
        chk("mid_capture", 64'(status_state), 64'd3);
        areset = 1'b1; drive(); tick();
        chk("rst2_state", 64'(status_state), 64'd0);
        chk("rst2_busy", 64'(status_busy), 64'd0);
        chk("rst2_mvalid", 64'(m_tvalid), 64'd0);
        chk("rst2_tdata", 64'(m_tdata), 64'd0);
        chk("rst2_tlast", 64'(m_tlast), 64'd0);
        chk("rst2_dropped", 64'(status_dropped), 64'd0);
        chk("rst2_sready", 64'(s_tready), 64'd1);
        areset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
